// File: rtl/chunked_add_sequencer_pkg.sv
// Shared definitions for the chunked wide-operand adder front end:
// FSM state encoding and the chunking geometry helpers.
package chunked_add_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of CHUNK_WIDTH slices needed to cover an operand (ceiling division).
   function automatic int calc_num_chunks(input int op_w, input int chunk_w);
      return (op_w + chunk_w - 32'sd1) / chunk_w;
   endfunction

   // Width of the most significant slice; equals chunk_w when op_w divides evenly.
   function automatic int calc_last_w(input int op_w, input int chunk_w);
      return op_w - (calc_num_chunks(op_w, chunk_w) - 32'sd1) * chunk_w;
   endfunction

   // Chunk index width; a single-chunk configuration still needs one bit.
   function automatic int calc_idx_w(input int num_chunks);
      return (num_chunks <= 32'sd1) ? 32'sd1 : $clog2(num_chunks);
   endfunction

endpackage

// File: rtl/chunked_add_sequencer_adder.sv
// Combinational conditional-sum adder. The operand is cut into BLOCK_SIZE
// slices; each slice precomputes its sum for an incoming carry of 0 and of 1,
// and the real block carries only steer multiplexers, keeping the ripple
// path to one mux per block.
module configurable_conditional_sum_adder #(
   parameter int DATA_WIDTH = 32,
   parameter int BLOCK_SIZE = 4
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  cin,
   output logic [DATA_WIDTH-1:0] sum,
   output logic                  cout
);

   localparam int NUM_BLOCKS = (DATA_WIDTH + BLOCK_SIZE - 1) / BLOCK_SIZE;

   logic [NUM_BLOCKS:0] block_carry;

   assign block_carry[0] = cin;

   for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_block
      localparam int LO = g * BLOCK_SIZE;
      // The top block is narrower when BLOCK_SIZE does not divide DATA_WIDTH.
      localparam int BW = ((LO + BLOCK_SIZE) > DATA_WIDTH) ? (DATA_WIDTH - LO) : BLOCK_SIZE;

      logic [BW:0] sum_c0;
      logic [BW:0] sum_c1;

      assign sum_c0 = {1'b0, a[LO +: BW]} + {1'b0, b[LO +: BW]};
      assign sum_c1 = sum_c0 + {{BW{1'b0}}, 1'b1};

      assign sum[LO +: BW]      = block_carry[g] ? sum_c1[BW-1:0] : sum_c0[BW-1:0];
      assign block_carry[g + 1] = block_carry[g] ? sum_c1[BW]     : sum_c0[BW];
   end

   assign cout = block_carry[NUM_BLOCKS];

endmodule

// File: rtl/chunked_add_sequencer.sv
// Multi-cycle wide adder: captures two OP_WIDTH operands, then pushes one
// CHUNK_WIDTH slice per cycle (LSB first) through a single conditional-sum
// core, carrying between slices in a register and assembling the full sum.
module chunked_add_sequencer
   import chunked_add_sequencer_pkg::*;
#(
   parameter int OP_WIDTH    = 128,
   parameter int CHUNK_WIDTH = 32,
   parameter int BLOCK_SIZE  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OP_WIDTH-1:0] in_a,
   input  logic [OP_WIDTH-1:0] in_b,
   input  logic                in_cin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OP_WIDTH-1:0] out_sum,
   output logic                out_cout,
   output logic                busy
);

   localparam int NUM_CHUNKS = calc_num_chunks(OP_WIDTH, CHUNK_WIDTH);
   localparam int LAST_W     = calc_last_w(OP_WIDTH, CHUNK_WIDTH);
   localparam int IDX_W      = calc_idx_w(NUM_CHUNKS);
   localparam int PAD_W      = NUM_CHUNKS * CHUNK_WIDTH;
   localparam int SLOTS      = 2 ** IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   state_t                 state;
   logic [OP_WIDTH-1:0]    a_reg;
   logic [OP_WIDTH-1:0]    b_reg;
   logic [OP_WIDTH-1:0]    result;
   logic [OP_WIDTH-1:0]    result_next;
   logic                   carry;
   logic [IDX_W-1:0]       idx;

   logic [PAD_W-1:0]       a_pad;
   logic [PAD_W-1:0]       b_pad;
   logic [CHUNK_WIDTH-1:0] a_chunks [SLOTS];
   logic [CHUNK_WIDTH-1:0] b_chunks [SLOTS];
   logic [CHUNK_WIDTH-1:0] core_a;
   logic [CHUNK_WIDTH-1:0] core_b;
   logic [CHUNK_WIDTH-1:0] core_sum;
   logic                   core_cout;
   logic                   chunk_carry;

   // Zero-extension pads a partial top chunk so its unused upper bits add as 0.
   assign a_pad = PAD_W'(a_reg);
   assign b_pad = PAD_W'(b_reg);

   // Chunk table sized to the full index range so every idx value selects a defined entry.
   for (genvar c = 0; c < SLOTS; c++) begin : g_chunk_mux
      if (c < NUM_CHUNKS) begin : g_real
         assign a_chunks[c] = a_pad[c*CHUNK_WIDTH +: CHUNK_WIDTH];
         assign b_chunks[c] = b_pad[c*CHUNK_WIDTH +: CHUNK_WIDTH];
      end else begin : g_unused
         assign a_chunks[c] = {CHUNK_WIDTH{1'b0}};
         assign b_chunks[c] = {CHUNK_WIDTH{1'b0}};
      end
   end

   assign core_a = a_chunks[idx];
   assign core_b = b_chunks[idx];

   configurable_conditional_sum_adder #(
      .DATA_WIDTH (CHUNK_WIDTH),
      .BLOCK_SIZE (BLOCK_SIZE)
   ) u_core (
      .a    (core_a),
      .b    (core_b),
      .cin  (carry),
      .sum  (core_sum),
      .cout (core_cout)
   );

   // Only the slice selected by idx takes the core sum; the rest keep their value.
   for (genvar c = 0; c < NUM_CHUNKS; c++) begin : g_result
      localparam int CW = (c == NUM_CHUNKS - 1) ? LAST_W : CHUNK_WIDTH;
      assign result_next[c*CHUNK_WIDTH +: CW] =
         (idx == IDX_W'(c)) ? core_sum[CW-1:0] : result[c*CHUNK_WIDTH +: CW];
   end

   // With a partial top chunk the true carry-out sits at padded-sum bit LAST_W.
   if (LAST_W < CHUNK_WIDTH) begin : g_partial_carry
      assign chunk_carry = (idx == LAST_IDX) ? core_sum[LAST_W] : core_cout;
   end else begin : g_full_carry
      assign chunk_carry = core_cout;
   end

   // Sequencer FSM: capture, one chunk per RUN cycle, hold result until consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         a_reg     <= {OP_WIDTH{1'b0}};
         b_reg     <= {OP_WIDTH{1'b0}};
         result    <= {OP_WIDTH{1'b0}};
         carry     <= 1'b0;
         idx       <= {IDX_W{1'b0}};
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg    <= in_a;
                  b_reg    <= in_b;
                  carry    <= in_cin;
                  idx      <= {IDX_W{1'b0}};
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               result <= result_next;
               carry  <= chunk_carry;
               idx    <= idx + IDX_W'(1'b1);
               if (idx == LAST_IDX) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign out_sum  = result;
   assign out_cout = carry;

endmodule
